// File: rtl/m_csr_responder.sv
// m_csr_responder: M-mode CSR command responder with WARL trap CSRs, trap entry and MRET.
// Ports: req_* CSR command in, rsp_* old value/illegal out, trap_*/mret_i hardware trap
// events, msip/mtip/meip interrupt lines, trap_target/mepc/privilege/irq_* status out.
// Optional feature: define VECTORED_MTVEC_EN for writable mtvec vectored mode.
module m_csr_responder #(
  parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MISA_VALUE  = 64'h8000_0000_0010_1100
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_command_i,
  input  logic [11:0] req_address_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_cause_i,
  input  logic [63:0] trap_pc_i,
  input  logic [63:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        msip_i,
  input  logic        mtip_i,
  input  logic        meip_i,
  output logic [63:0] trap_target_o,
  output logic [63:0] mepc_o,
  output logic [1:0]  privilege_o,
  output logic        irq_pending_o,
  output logic [63:0] irq_cause_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_next;
  logic [1:0] priv, mpp, mode_new;
  logic st_mie, st_mpie, decoded, write_cmd, known_cmd, illegal, accept, do_write;
  logic [63:0] mie, mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mip, mstatus, old, wval, base, pend;
  assign mip = {52'b0, meip_i, 3'b0, mtip_i, 3'b0, msip_i, 3'b0};
  assign mstatus = {51'b0, mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  always_comb begin
    decoded = 1'b1;
    old = '0;
    case (req_address_i)
      12'h300: old = mstatus;
      12'h301: old = MISA_VALUE;
      12'h302, 12'h303, 12'h306, 12'h34A, 12'h34B: old = '0;
      12'h304: old = mie;
      12'h305: old = mtvec;
      12'h340: old = mscratch;
      12'h341: old = mepc;
      12'h342: old = mcause;
      12'h343: old = mtval;
      12'h344: old = mip;
      default: decoded = 1'b0;
    endcase
  end
  assign write_cmd = req_command_i inside {4'b0001, 4'b0010, 4'b0011, 4'b1000};
  assign known_cmd = write_cmd || req_command_i == 4'b0101;
  assign illegal = !decoded || priv < req_address_i[9:8] ||
                   (write_cmd && req_address_i[11:10] == 2'b11) || !known_cmd;
  assign wval = req_command_i == 4'b0010 ? old | req_wdata_i :
                req_command_i == 4'b0011 ? old & ~req_wdata_i : req_wdata_i;
  assign accept = req_valid_i && req_ready_o;
  assign do_write = accept && !illegal && write_cmd;
  assign base = {mtvec[63:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
  // Reserved modes 10/11 leave the current mode in place.
  assign mode_new = wval[1] ? mtvec[1:0] : wval[1:0];
  assign trap_target_o = mtvec[1:0] == 2'b01 && trap_cause_i[63] ?
                         base + {56'b0, trap_cause_i[5:0], 2'b00} : base;
`else
  assign mode_new = 2'b00;
  assign trap_target_o = base;
`endif
  assign pend = mip & mie;
  assign irq_pending_o = |pend && (priv < 2'b11 || st_mie);
  assign irq_cause_o = pend[11] ? 64'h8000_0000_0000_000B :
                       pend[3]  ? 64'h8000_0000_0000_0003 :
                       pend[7]  ? 64'h8000_0000_0000_0007 : '0;
  assign mepc_o = mepc;
  assign privilege_o = priv;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (state == IDLE && accept) state_next = RESP;
    else if (state == RESP && rsp_ready_i) state_next = IDLE;
  end
  always_comb begin
    req_ready_o = state == IDLE && !trap_valid_i && !mret_i;
    rsp_valid_o = state == RESP;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      rsp_rdata_o <= '0;
      rsp_illegal_o <= 1'b0;
    end else if (accept) begin
      rsp_rdata_o <= illegal || req_command_i == 4'b1000 ? '0 : old;
      rsp_illegal_o <= illegal;
    end
  // Requests are never accepted while a trap or MRET is presented, so the
  // priority chain below only orders trap over MRET.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      priv <= 2'b11;
      mpp <= 2'b00;
      st_mie <= 1'b0;
      st_mpie <= 1'b0;
      mie <= '0;
      mtvec <= MTVEC_RESET & ~64'h3;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
    end else if (trap_valid_i) begin
      mepc <= trap_pc_i & ~64'h3;
      mcause <= trap_cause_i;
      mtval <= trap_tval_i;
      st_mpie <= st_mie;
      st_mie <= 1'b0;
      mpp <= priv;
      priv <= 2'b11;
    end else if (mret_i) begin
      priv <= mpp;
      st_mie <= st_mpie;
      st_mpie <= 1'b1;
      mpp <= 2'b00;
    end else if (do_write) begin
      case (req_address_i)
        12'h300: begin
          st_mie <= wval[3];
          st_mpie <= wval[7];
          mpp <= wval[12] ^ wval[11] ? mpp : wval[12:11];
        end
        12'h304: mie <= wval & 64'h888;
        12'h305: mtvec <= {wval[63:2], mode_new};
        12'h340: mscratch <= wval;
        12'h341: mepc <= wval & ~64'h3;
        12'h342: mcause <= wval;
        12'h343: mtval <= wval;
        default: ;
      endcase
    end
endmodule
